// File: rtl/bm_pkg.sv
// Shared Box-Muller fixed-point formats and serialiser state encoding.
// Used by the log, sqrt, sincos and noise-multiply stages.
package bm_pkg;

    localparam int unsigned FW = 17;
    localparam int unsigned FF = 13;
    localparam int unsigned GW = 16;
    localparam int unsigned GF = 14;
    localparam int unsigned OW = 16;
    localparam int unsigned OF = 11;

    // Signed product of {1'b0,f} and g, plus the rounding shift back to the output format.
    localparam int unsigned PW = FW + 1 + GW;
    localparam int unsigned SH = FF + GF - OF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SEND0 = 2'd1,
        SEND1 = 2'd2
    } state_t;

endpackage

// File: rtl/bm_rnd_sat.sv
// Round-half-up, arithmetic shift by SH and saturate one product to the output format.
module bm_rnd_sat
    import bm_pkg::*;
(
    input  logic [PW-1:0] p,
    output logic [OW-1:0] x_c,
    output logic          sat_c
);

    localparam int unsigned SW = PW + 1;
    localparam int unsigned QW = SW - SH;
    localparam logic signed [SW-1:0] HALF = SW'(1) << (SH - 1);
    localparam logic signed [QW-1:0] QMAX = QW'(2 ** (OW - 1) - 1);
    localparam logic signed [QW-1:0] QMIN = ~QMAX;

    logic signed [SW-1:0] sum;
    logic signed [QW-1:0] q;

    // One extra bit of headroom keeps the rounding add from wrapping.
    always_comb begin
        sum   = $signed({p[PW-1], p}) + HALF;
        q     = QW'(sum >>> SH);
        x_c   = OW'(q);
        sat_c = 1'b0;
        if (q > QMAX) begin
            x_c   = {1'b0, {(OW-1){1'b1}}};
            sat_c = 1'b1;
        end else if (q < QMIN) begin
            x_c   = {1'b1, {(OW-1){1'b0}}};
            sat_c = 1'b1;
        end
    end

endmodule

// File: rtl/bm_noise_mult.sv
// Box-Muller output stage: x0 = f*g0, x1 = f*g1, rounded and saturated,
// then serialised as x0 followed by x1 on a single ready/valid stream.
module bm_noise_mult
    import bm_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [FW-1:0] f,
    input  logic [GW-1:0] g0,
    input  logic [GW-1:0] g1,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] out_data,
    output logic          out_last,
    output logic [15:0]   sat_cnt,
    output logic [31:0]   smp_cnt
);

    localparam int unsigned CW  = 16;
    localparam int unsigned SCW = CW + 1;
    localparam int unsigned NW  = 32;

    state_t          state;
    state_t          state_nxt;
    logic            v1;
    logic [PW-1:0]   p0;
    logic [PW-1:0]   p1;
    logic [OW-1:0]   x1_q;
    logic [OW-1:0]   r0;
    logic [OW-1:0]   r1;
    logic            s0;
    logic            s1;
    logic            adv_c;
    logic            load_c;
    logic            acc_c;
    logic [OW-1:0]   data_nxt;
    logic [SCW-1:0]  sat_sum;

    assign adv_c    = (state == IDLE) | ((state == SEND1) & out_ready);
    assign load_c   = adv_c & v1;
    assign in_ready = ~v1 | adv_c;
    assign acc_c    = in_valid & in_ready;

    // S1 occupancy: a new operand set wins over a drain in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1 <= 1'b0;
        end else if (acc_c) begin
            v1 <= 1'b1;
        end else if (adv_c) begin
            v1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (acc_c) begin
            p0 <= PW'($signed({1'b0, f})) * PW'($signed(g0));
            p1 <= PW'($signed({1'b0, f})) * PW'($signed(g1));
        end
        if (load_c) begin
            x1_q <= r1;
        end
    end

    bm_rnd_sat u_rs0 (
        .p     (p0),
        .x_c   (r0),
        .sat_c (s0)
    );

    bm_rnd_sat u_rs1 (
        .p     (p1),
        .x_c   (r1),
        .sat_c (s1)
    );

    // Serialiser next state and next output word; holds everything while stalled.
    always_comb begin
        state_nxt = state;
        data_nxt  = out_data;
        unique case (state)
            IDLE: begin
                if (v1) state_nxt = SEND0;
            end
            SEND0: begin
                if (out_ready) begin
                    state_nxt = SEND1;
                    data_nxt  = x1_q;
                end
            end
            SEND1: begin
                if (out_ready) state_nxt = v1 ? SEND0 : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (load_c) data_nxt = r0;
        sat_sum = {1'b0, sat_cnt} + SCW'(load_c & s0) + SCW'(load_c & s1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            sat_cnt   <= '0;
            smp_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            out_valid <= (state_nxt != IDLE);
            out_last  <= (state_nxt == SEND1);
            out_data  <= data_nxt;
            sat_cnt   <= sat_sum[CW] ? {CW{1'b1}} : sat_sum[CW-1:0];
            if (out_valid & out_ready) begin
                smp_cnt <= smp_cnt + NW'(1);
            end
        end
    end

endmodule

// File: tb/tb_bm_noise_mult.sv
// Directed and randomized bench for bm_noise_mult against an arithmetic reference queue.
module tb_bm_noise_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [16:0] f;
    logic [15:0] g0;
    logic [15:0] g1;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_last;
    logic [15:0] sat_cnt;
    logic [31:0] smp_cnt;

    bm_noise_mult dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .f         (f),
        .g0        (g0),
        .g1        (g1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .sat_cnt   (sat_cnt),
        .smp_cnt   (smp_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_sat   = 0;
    int   m_smp   = 0;
    int   edge_cnt = 0;
    bit   acc_seen;
    int   acc_edge;
    int   trk_n, trk_first, trk_last;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Real-valued product f*g scaled to (16,11): floor(p/2^16 + 1/2), then clamp.
    function automatic logic [15:0] ref_x(input logic [16:0] fv, input logic [15:0] gv, output bit sat);
        longint p, q;
        p   = longint'(fv) * longint'($signed(gv));
        q   = (p + 64'sd32768) >>> 16;
        sat = 1'b0;
        if (q > 32767) begin
            sat = 1'b1;
            q   = 32767;
        end else if (q < -32768) begin
            sat = 1'b1;
            q   = -32768;
        end
        return 16'(q);
    endfunction

    task automatic push_model();
        bit   sa, sb;
        exp_t e;
        e.data = ref_x(f, g0, sa);
        e.last = 1'b0;
        exp_q.push_back(e);
        e.data = ref_x(f, g1, sb);
        e.last = 1'b1;
        exp_q.push_back(e);
        m_sat += int'(sa) + int'(sb);
    endtask

    // One clock: sample handshakes just after the negedge, advance to the next negedge.
    task automatic tick();
        bit   hs;
        exp_t e;
        #1;
        acc_seen = 1'b0;
        hs = out_valid && out_ready && rst_n;
        if (in_valid && in_ready && rst_n) begin
            push_model();
            acc_seen = 1'b1;
            acc_edge = edge_cnt;
        end
        if (hs) begin
            if (trk_n == 0) trk_first = edge_cnt;
            trk_last = edge_cnt;
            trk_n++;
            chk("exp_avail", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("out_data", 32'(out_data), 32'(e.data));
                chk("out_last", 32'(out_last), 32'(e.last));
            end
        end
        @(posedge clk);
        edge_cnt++;
        if (hs) m_smp++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [16:0] fv, input logic [15:0] a, input logic [15:0] b);
        int n;
        n        = 0;
        f        = fv;
        g0       = a;
        g1       = b;
        in_valid = 1'b1;
        do begin
            tick();
            n++;
        end while (!acc_seen && n < 50);
        chk("send_accept", 32'(acc_seen), 32'd1);
        in_valid = 1'b0;
    endtask

    initial begin
        logic [15:0] held;
        int          pairs;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        f         = '0;
        g0        = '0;
        g1        = '0;
        trk_n     = 0;
        @(negedge clk);
        drain(2);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_sat_cnt",   32'(sat_cnt),   32'd0);
        chk("rst_smp_cnt",   smp_cnt,        32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b1;

        // Unity gain: x0 = +1.0, x1 = -1.0, two-edge latency to the x0 hand-off.
        trk_n = 0;
        send(17'h02000, 16'h4000, 16'hC000);
        drain(6);
        chk("t1_lat_x0", 32'(trk_first - acc_edge), 32'd2);
        chk("t1_lat_x1", 32'(trk_last - acc_edge),  32'd3);
        chk("t1_count",  32'(trk_n),                32'd2);

        // Positive overflow saturates; the exact negative limit does not.
        send(17'h1FFFF, 16'h4000, 16'hC000);
        drain(6);
        chk("t2_sat_cnt", 32'(sat_cnt), 32'd1);

        // Half-LSB rounds up, quarter-LSB rounds down.
        send(17'h00002, 16'h4000, 16'h0000);
        send(17'h00001, 16'h4000, 16'h0000);
        drain(6);
        chk("t3_smp_cnt", smp_cnt, 32'(m_smp));

        // Downstream stall with input pressure.
        out_ready = 1'b0;
        trk_n     = 0;
        held      = '0;
        f         = 17'($urandom);
        g0        = 16'($urandom);
        g1        = 16'($urandom);
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (acc_seen) begin
                f  = 17'($urandom);
                g0 = 16'($urandom);
                g1 = 16'($urandom);
            end
            if (i == 1) held = out_data;
            if (i >= 1) chk("t4_in_ready", 32'(in_ready), 32'd0);
            if (i >= 2) begin
                chk("t4_hold_data",  32'(out_data),  32'(held));
                chk("t4_hold_valid", 32'(out_valid), 32'd1);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain(10);
        chk("t4_samples", 32'(trk_n), 32'd4);
        chk("t4_smp_cnt", smp_cnt, 32'(m_smp));

        // 100 random pairs, continuous flow: 200 samples on consecutive edges.
        trk_n    = 0;
        pairs    = 0;
        f        = 17'($urandom);
        g0       = 16'($urandom);
        g1       = 16'($urandom);
        in_valid = 1'b1;
        for (int i = 0; i < 400 && (pairs < 100 || exp_q.size() != 0); i++) begin
            tick();
            if (acc_seen) begin
                pairs++;
                f  = 17'($urandom);
                g0 = 16'($urandom);
                g1 = 16'($urandom);
            end
            if (pairs >= 100) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        drain(3);
        chk("t5_samples", 32'(trk_n), 32'd200);
        chk("t5_no_gaps", 32'(trk_last - trk_first), 32'd199);
        chk("t5_sat_cnt", 32'(sat_cnt), 32'(m_sat));
        chk("t5_smp_cnt", smp_cnt, 32'(m_smp));

        // Reset while x1 is stalled on the output.
        send(17'h0A5A5, 16'h2345, 16'hD123);
        tick();
        tick();
        out_ready = 1'b0;
        tick();
        chk("t6_in_send1", 32'(out_last), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("t6_out_valid", 32'(out_valid), 32'd0);
        chk("t6_out_last",  32'(out_last),  32'd0);
        chk("t6_sat_cnt",   32'(sat_cnt),   32'd0);
        chk("t6_smp_cnt",   smp_cnt,        32'd0);
        exp_q.delete();
        m_sat     = 0;
        m_smp     = 0;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        trk_n     = 0;
        send(17'h03000, 16'h2000, 16'hE000);
        drain(6);
        chk("t6_samples", 32'(trk_n), 32'd2);
        chk("t6_smp_cnt_after", smp_cnt, 32'd2);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
